// File: rtl/brdg_interrupt_mc_pkg.sv
// Shared constants and types for the multi-channel interrupt bridge.
// Latency: n/a (package). Backpressure: n/a.
// Holds TLX opcodes, response codes, the afutag prefix, the one-hot channel
// state encoding and the saturating backoff-duration helper.
package brdg_int_pkg;

  localparam logic [7:0] INTRP_REQ  = 8'h58;
  localparam logic [7:0] INTRP_RESP = 8'h0C;
  localparam logic [7:0] INTRP_RDY  = 8'h1A;

  localparam logic [3:0] RSP_DONE          = 4'h0;
  localparam logic [3:0] RSP_RTY_REQ       = 4'h2;
  localparam logic [3:0] RSP_INTRP_PENDING = 4'h4;
  localparam logic [3:0] RSP_DERROR        = 4'h8;
  localparam logic [3:0] RSP_BAD_LENGTH    = 4'h9;
  localparam logic [3:0] RSP_BAD_HANDLE    = 4'hB;
  localparam logic [3:0] RSP_FAILED        = 4'hE;

  // Upper afutag bits that mark a command as belonging to this engine.
  localparam logic [1:0] TAG_PREFIX = 2'b11;

  localparam int OBJ_W   = 68;
  localparam int TIMER_W = 24;

  typedef enum logic [5:0] {
    CH_IDLE    = 6'b000001,
    CH_REQ     = 6'b000010,
    CH_WAIT    = 6'b000100,
    CH_PEND    = 6'b001000,
    CH_BACKOFF = 6'b010000,
    CH_ACK     = 6'b100000
  } ch_state_e;

  // base << min(exp_sum, 15), clamped to the 24-bit timer range rather than
  // wrapping, so large exponents give the longest possible wait.
  function automatic logic [TIMER_W-1:0] backoff_ticks(input int unsigned base,
                                                       input logic [4:0] exp_sum);
    logic [4:0]  e;
    logic [63:0] wide;
    e    = (exp_sum > 5'd15) ? 5'd15 : exp_sum;
    wide = 64'(base) << e;
    if (wide > 64'h0000_0000_00FF_FFFF) begin
      return 24'hFF_FFFF;
    end
    return wide[TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/brdg_interrupt_mc_if.sv
// TLX command/response bundle between the interrupt bridge and the TLX mux.
// Latency: n/a (wires only). Backpressure: none; commands are fire-and-forget strobes.
// master: bridge side (drives cmd_*, samples rsp_*); slave: TLX side.
interface brdg_interrupt_mc_if;
  logic        tlx_cmd_valid;
  logic [67:0] tlx_cmd_obj;
  logic [15:0] tlx_cmd_afutag;
  logic [7:0]  tlx_cmd_opcode;

  logic        tlx_rsp_valid;
  logic [15:0] tlx_rsp_afutag;
  logic [7:0]  tlx_rsp_opcode;
  logic [3:0]  tlx_rsp_code;

  modport master (
    output tlx_cmd_valid, tlx_cmd_obj, tlx_cmd_afutag, tlx_cmd_opcode,
    input  tlx_rsp_valid, tlx_rsp_afutag, tlx_rsp_opcode, tlx_rsp_code
  );

  modport slave (
    input  tlx_cmd_valid, tlx_cmd_obj, tlx_cmd_afutag, tlx_cmd_opcode,
    output tlx_rsp_valid, tlx_rsp_afutag, tlx_rsp_opcode, tlx_rsp_code
  );
endinterface

// File: rtl/brdg_interrupt_mc_channel.sv
// One interrupt channel: request FSM, retry budget and exponential backoff timer.
// Latency: IDLE->REQ one cycle after irq; response acted on in the cycle it arrives.
// Backpressure: waits in REQ until granted; no abort once started.
// Ports: irq level in, grant/rsp_vld/rsp_code from the top, state/ack/fail out.
module brdg_int_channel
  import brdg_int_pkg::*;
#(
  parameter int          MAX_RETRY  = 7,
  parameter int unsigned BASE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq,
  input  logic [3:0] backoff_limit,
  input  logic       grant,
  input  logic       rsp_vld,     // already qualified to this channel's state
  input  logic [3:0] rsp_code,
  output ch_state_e  state,
  output logic       ack,
  output logic       fail
);

  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  ch_state_e            state_q, state_d;
  logic [3:0]           retry_q, retry_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 fail_q, fail_d;
  logic                 enter_backoff;
  logic                 retry_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      retry_q <= '0;
      timer_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    fail_d        = fail_q;
    enter_backoff = 1'b0;
    retry_req     = 1'b0;

    unique case (state_q)
      CH_IDLE: begin
        if (irq) state_d = CH_REQ;
      end
      CH_REQ: begin
        if (grant) state_d = CH_WAIT;
      end
      CH_WAIT: begin
        if (rsp_vld) begin
          case (rsp_code)
            RSP_DONE: begin
              state_d = CH_ACK;
              fail_d  = 1'b0;
            end
            RSP_RTY_REQ:       enter_backoff = 1'b1;
            RSP_INTRP_PENDING: state_d = CH_PEND;
            RSP_FAILED, RSP_DERROR, RSP_BAD_LENGTH, RSP_BAD_HANDLE: begin
              state_d = CH_ACK;
              fail_d  = 1'b1;
            end
            default: begin
              state_d = CH_ACK;
              fail_d  = 1'b1;
            end
          endcase
        end
      end
      CH_PEND: begin
        if (rsp_vld) begin
          case (rsp_code)
            RSP_DONE:    retry_req     = 1'b1;
            RSP_RTY_REQ: enter_backoff = 1'b1;
            default: begin
              state_d = CH_ACK;
              fail_d  = 1'b1;
            end
          endcase
        end
      end
      CH_BACKOFF: begin
        // Timer holds the number of cycles still to spend here.
        if (timer_q <= 24'd1) begin
          timer_d   = '0;
          retry_req = 1'b1;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
      CH_ACK: begin
        if (!irq) begin
          state_d = CH_IDLE;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = CH_IDLE;
    endcase

    // Duration uses the retry count before this retry is charged.
    if (enter_backoff) begin
      state_d = CH_BACKOFF;
      timer_d = backoff_ticks(BASE_TICKS, {1'b0, backoff_limit} + {1'b0, retry_q});
    end

    if (retry_req) begin
      if (retry_q == MAX_RETRY_L) begin
        state_d = CH_ACK;
        fail_d  = 1'b1;
      end else begin
        state_d = CH_REQ;
        retry_d = retry_q + 4'd1;
      end
    end
  end

  assign state = state_q;
  assign ack   = (state_q == CH_ACK);
  assign fail  = (state_q == CH_ACK) && fail_q;

endmodule

// File: rtl/brdg_interrupt_mc.sv
// Multi-channel interrupt bridge: round-robin issue of TLX intrp_req, response routing.
// Latency: tlx_cmd_valid one cycle after the grant; err_unexp_rsp one cycle after the bad response.
// Backpressure: interrupt_enable=0 stalls grants only; responses and timers keep running.
// Ports: clk/rst_n, backoff_limit, interrupt_enable, interrupt/interrupt_src in,
//        interrupt_ack/interrupt_fail/err_unexp_rsp out, tlx (cmd out, rsp in).
module brdg_interrupt_mc
  import brdg_int_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          SRC_W      = 64,
  parameter int          MAX_RETRY  = 7,
  parameter int unsigned BASE_TICKS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              backoff_limit,
  input  logic                    interrupt_enable,
  input  logic [NUM_CH-1:0]       interrupt,
  input  logic [NUM_CH*SRC_W-1:0] interrupt_src,
  output logic [NUM_CH-1:0]       interrupt_ack,
  output logic [NUM_CH-1:0]       interrupt_fail,
  output logic                    err_unexp_rsp,
  brdg_interrupt_mc_if.master     tlx
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = PTR_W + 1;

  ch_state_e          ch_state [NUM_CH];
  logic [NUM_CH-1:0]  ch_req;
  logic [NUM_CH-1:0]  grant;
  logic [NUM_CH-1:0]  rsp_vld;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   idx_w;
  logic [SRC_W-1:0]   gnt_src;

  logic               rsp_hit;
  logic               rsp_is_resp;
  logic               rsp_is_rdy;
  logic [13:0]        rsp_ch;

  // Response decode: only intrp opcodes carrying our tag prefix are looked at.
  assign rsp_is_resp = (tlx.tlx_rsp_opcode == INTRP_RESP);
  assign rsp_is_rdy  = (tlx.tlx_rsp_opcode == INTRP_RDY);
  assign rsp_ch      = tlx.tlx_rsp_afutag[13:0];
  assign rsp_hit     = tlx.tlx_rsp_valid && (tlx.tlx_rsp_afutag[15:14] == TAG_PREFIX) &&
                       (rsp_is_resp || rsp_is_rdy);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_req[i]  = (ch_state[i] == CH_REQ);
    assign grant[i]   = gnt_any && (gnt_idx == PTR_W'(i));
    assign rsp_vld[i] = rsp_hit && (rsp_ch == 14'(i)) &&
                        ((rsp_is_resp && ch_state[i] == CH_WAIT) ||
                         (rsp_is_rdy  && ch_state[i] == CH_PEND));

    brdg_int_channel #(
      .MAX_RETRY  (MAX_RETRY),
      .BASE_TICKS (BASE_TICKS)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq           (interrupt[i]),
      .backoff_limit (backoff_limit),
      .grant         (grant[i]),
      .rsp_vld       (rsp_vld[i]),
      .rsp_code      (tlx.tlx_rsp_code),
      .state         (ch_state[i]),
      .ack           (interrupt_ack[i]),
      .fail          (interrupt_fail[i])
    );
  end

  // Round-robin search starting at ptr_q; first requester found wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    if (interrupt_enable) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx_w = {1'b0, ptr_q} + IDX_W'(k);
        if (idx_w >= IDX_W'(NUM_CH)) idx_w = idx_w - IDX_W'(NUM_CH);
        if (!gnt_any && ch_req[idx_w[PTR_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = idx_w[PTR_W-1:0];
        end
      end
    end
  end

  assign ptr_nxt = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    gnt_src = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == PTR_W'(i)) gnt_src = interrupt_src[i*SRC_W +: SRC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q              <= '0;
      tlx.tlx_cmd_valid  <= 1'b0;
      tlx.tlx_cmd_obj    <= '0;
      tlx.tlx_cmd_afutag <= '0;
      tlx.tlx_cmd_opcode <= '0;
      err_unexp_rsp      <= 1'b0;
    end else begin
      tlx.tlx_cmd_valid <= gnt_any;
      if (gnt_any) begin
        ptr_q              <= ptr_nxt;
        tlx.tlx_cmd_obj    <= OBJ_W'(gnt_src);
        tlx.tlx_cmd_afutag <= {TAG_PREFIX, 14'(gnt_idx)};
        tlx.tlx_cmd_opcode <= INTRP_REQ;
      end
      // Out-of-range tags and wrong-state responses are both "accepted by nobody".
      err_unexp_rsp <= rsp_hit && (rsp_vld == '0);
    end
  end

endmodule

// File: tb/tb_brdg_interrupt_mc.sv
module tb_brdg_interrupt_mc;
  import brdg_int_pkg::*;

  localparam int NCH = 4;
  localparam int SW  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        backoff_limit;
  logic              interrupt_enable;
  logic [NCH-1:0]    irq, ack, fail;
  logic [NCH*SW-1:0] src;
  logic              err;

  logic [NCH-1:0]    irq2, ack2, fail2;
  logic [NCH*SW-1:0] src2;
  logic              err2;

  brdg_interrupt_mc_if tif ();
  brdg_interrupt_mc_if tif2 ();

  brdg_interrupt_mc #(.NUM_CH(NCH), .SRC_W(SW), .MAX_RETRY(7), .BASE_TICKS(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .backoff_limit(backoff_limit),
    .interrupt_enable(interrupt_enable), .interrupt(irq), .interrupt_src(src),
    .interrupt_ack(ack), .interrupt_fail(fail), .err_unexp_rsp(err), .tlx(tif)
  );

  brdg_interrupt_mc #(.NUM_CH(NCH), .SRC_W(SW), .MAX_RETRY(2), .BASE_TICKS(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .backoff_limit(4'd0),
    .interrupt_enable(1'b1), .interrupt(irq2), .interrupt_src(src2),
    .interrupt_ack(ack2), .interrupt_fail(fail2), .err_unexp_rsp(err2), .tlx(tif2)
  );

  typedef struct {
    logic [67:0] obj;
    logic [15:0] tag;
    logic [7:0]  op;
    int          cyc;
  } cmd_t;

  typedef struct {
    int          ch;
    logic [63:0] src;
    logic [3:0]  code;
    logic        exp_fail;
  } vec_t;

  cmd_t cmd_q[$];
  int   cyc = 0;
  int   err_cnt = 0;
  int   cmd2_n = 0;
  int   rsp_cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cmd_t c;
    if (tif.tlx_cmd_valid) begin
      c.obj = tif.tlx_cmd_obj;
      c.tag = tif.tlx_cmd_afutag;
      c.op  = tif.tlx_cmd_opcode;
      c.cyc = cyc;
      cmd_q.push_back(c);
    end
    if (err) err_cnt++;
    if (tif2.tlx_cmd_valid) cmd2_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cmd(input int n, input int budget, input string nm);
    int k = 0;
    while (cmd_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (cmd_q.size() < n) timeout(nm);
  endtask

  task automatic send_rsp(input int which, input logic [15:0] tag, input logic [7:0] op,
                          input logic [3:0] code);
    if (which == 0) begin
      tif.tlx_rsp_valid = 1'b1; tif.tlx_rsp_afutag = tag;
      tif.tlx_rsp_opcode = op;  tif.tlx_rsp_code = code;
    end else begin
      tif2.tlx_rsp_valid = 1'b1; tif2.tlx_rsp_afutag = tag;
      tif2.tlx_rsp_opcode = op;  tif2.tlx_rsp_code = code;
    end
    @(posedge clk);
    #1;
    rsp_cyc = cyc;
    tif.tlx_rsp_valid  = 1'b0;
    tif2.tlx_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq   = '0;
    irq2  = '0;
    tif.tlx_rsp_valid  = 1'b0;
    tif2.tlx_rsp_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cmd_q.delete();
    cmd2_n = 0;
  endtask

  vec_t vecs[7];

  initial begin
    int e0;
    int k;
    int gap;
    logic [NCH-1:0] m;
    logic [15:0] tg;

    vecs[0] = '{2, 64'h0000_0000_DEAD_BEEF, RSP_DONE,       1'b0};
    vecs[1] = '{0, 64'h0123_4567_89AB_CDEF, RSP_FAILED,     1'b1};
    vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, RSP_DERROR,     1'b1};
    vecs[3] = '{3, 64'h8000_0000_0000_0001, RSP_BAD_LENGTH, 1'b1};
    vecs[4] = '{2, 64'h0000_0000_0000_0000, RSP_BAD_HANDLE, 1'b1};
    vecs[5] = '{0, 64'h5555_AAAA_5555_AAAA, 4'h5,           1'b1};
    vecs[6] = '{3, 64'h0000_0000_0000_CAFE, RSP_DONE,       1'b0};

    backoff_limit = 4'd0;
    interrupt_enable = 1'b1;
    irq = '0; src = '0; irq2 = '0; src2 = '0;
    tif.tlx_rsp_valid = 1'b0;  tif.tlx_rsp_afutag = '0;  tif.tlx_rsp_opcode = '0;  tif.tlx_rsp_code = '0;
    tif2.tlx_rsp_valid = 1'b0; tif2.tlx_rsp_afutag = '0; tif2.tlx_rsp_opcode = '0; tif2.tlx_rsp_code = '0;

    // Reset state.
    tick(2);
    check("rst ack", 68'(ack), 68'h0);
    check("rst fail", 68'(fail), 68'h0);
    check("rst err", 68'(err), 68'h0);
    check("rst cmd_valid", 68'(tif.tlx_cmd_valid), 68'h0);
    check("rst cmd_obj", tif.tlx_cmd_obj, 68'h0);
    check("rst cmd_tag", 68'(tif.tlx_cmd_afutag), 68'h0);
    check("rst cmd_op", 68'(tif.tlx_cmd_opcode), 68'h0);
    rst_n = 1'b1;
    tick(1);

    // Single-channel transactions from the table.
    for (int v = 0; v < 7; v++) begin
      cmd_q.delete();
      tg = {2'b11, 14'(vecs[v].ch)};
      src[vecs[v].ch*SW +: SW] = vecs[v].src;
      irq[vecs[v].ch] = 1'b1;
      wait_cmd(1, 20, "vec cmd");
      if (cmd_q.size() > 0) begin
        check("vec obj", cmd_q[0].obj, {4'h0, vecs[v].src});
        check("vec tag", 68'(cmd_q[0].tag), 68'(tg));
        check("vec op", 68'(cmd_q[0].op), 68'h58);
      end
      send_rsp(0, tg, 8'h0C, vecs[v].code);
      check("vec ack", 68'(ack), 68'(4'b0001 << vecs[v].ch));
      check("vec fail", 68'(fail[vecs[v].ch]), 68'(vecs[v].exp_fail));
      tick(3);
      check("vec ack held", 68'(ack[vecs[v].ch]), 68'h1);
      check("vec cmd count", 68'(cmd_q.size()), 68'd1);
      irq[vecs[v].ch] = 1'b0;
      tick(1);
      check("vec ack drop", 68'(ack), 68'h0);
    end

    // All channels at once: grants in tag order, responses in reverse.
    do_reset();
    for (int i = 0; i < NCH; i++) src[i*SW +: SW] = 64'h1000 + 64'(i);
    irq = 4'hF;
    wait_cmd(4, 30, "all cmds");
    if (cmd_q.size() == 4) begin
      for (int i = 0; i < NCH; i++) begin
        check("all tag", 68'(cmd_q[i].tag), 68'(16'hC000 + 16'(i)));
        check("all obj", cmd_q[i].obj, 68'h1000 + 68'(i));
        check("all spacing", 68'(cmd_q[i].cyc - cmd_q[0].cyc), 68'(i));
      end
    end
    m = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      send_rsp(0, 16'hC000 + 16'(i), 8'h0C, RSP_DONE);
      m[i] = 1'b1;
      check("all ack", 68'(ack), 68'(m));
    end
    check("all fail", 68'(fail), 68'h0);
    irq = '0;
    tick(1);
    check("all ack drop", 68'(ack), 68'h0);

    // Exponential backoff on channel 0: 20, 40, 80 cycles.
    do_reset();
    backoff_limit = 4'd0;
    src[0 +: SW] = 64'hB0;
    irq[0] = 1'b1;
    wait_cmd(1, 20, "bo first");
    for (int a = 0; a < 3; a++) begin
      send_rsp(0, 16'hC000, 8'h0C, RSP_RTY_REQ);
      wait_cmd(a + 2, (20 << a) + 20, "bo retry");
      if (cmd_q.size() == a + 2) begin
        gap = cmd_q[a + 1].cyc - rsp_cyc;
        check_rng("bo gap", gap, (20 << a) - 1, (20 << a) + 1);
      end
    end
    send_rsp(0, 16'hC000, 8'h0C, RSP_DONE);
    check("bo ack", 68'(ack[0]), 68'h1);
    check("bo fail", 68'(fail[0]), 68'h0);
    check("bo cmd count", 68'(cmd_q.size()), 68'd4);
    irq[0] = 1'b0;
    tick(1);

    // Pending then ready on channel 1; stray responses elsewhere.
    cmd_q.delete();
    irq[1] = 1'b1;
    wait_cmd(1, 20, "pend cmd");
    send_rsp(0, 16'hC001, 8'h0C, RSP_INTRP_PENDING);
    tick(5);
    check("pend no reissue", 68'(cmd_q.size()), 68'd1);
    check("pend no ack", 68'(ack[1]), 68'h0);
    send_rsp(0, 16'hC001, 8'h1A, RSP_DONE);
    wait_cmd(2, 10, "pend reissue");
    if (cmd_q.size() == 2) begin
      check("pend reissue gap", 68'(cmd_q[1].cyc - rsp_cyc), 68'd1);
      check("pend reissue tag", 68'(cmd_q[1].tag), 68'hC001);
    end
    e0 = err_cnt;
    send_rsp(0, 16'hC003, 8'h1A, RSP_DONE);
    tick(3);
    check("rdy idle err", 68'(err_cnt - e0), 68'd1);
    check("rdy idle ack", 68'(ack), 68'h0);
    check("rdy idle no cmd", 68'(cmd_q.size()), 68'd2);
    e0 = err_cnt;
    send_rsp(0, 16'hC007, 8'h0C, RSP_DONE);
    tick(3);
    check("range err", 68'(err_cnt - e0), 68'd1);
    e0 = err_cnt;
    send_rsp(0, 16'h4001, 8'h0C, RSP_DONE);
    tick(3);
    check("foreign tag err", 68'(err_cnt - e0), 68'd0);
    check("foreign tag ack", 68'(ack[1]), 68'h0);
    send_rsp(0, 16'hC001, 8'h0C, RSP_DONE);
    check("pend ack", 68'(ack), 68'h2);
    check("pend fail", 68'(fail), 68'h0);
    irq[1] = 1'b0;
    tick(1);

    // Enable gating.
    cmd_q.delete();
    interrupt_enable = 1'b0;
    irq[2] = 1'b1;
    tick(10);
    check("en stall", 68'(cmd_q.size()), 68'd0);
    interrupt_enable = 1'b1;
    k = cyc;
    wait_cmd(1, 10, "en cmd");
    if (cmd_q.size() == 1) check("en latency", 68'(cmd_q[0].cyc - k), 68'd1);
    send_rsp(0, 16'hC002, 8'h0C, RSP_DONE);
    check("en ack", 68'(ack[2]), 68'h1);
    irq[2] = 1'b0;
    tick(1);

    // Reset while a channel waits for its response.
    cmd_q.delete();
    src[0 +: SW] = 64'h77;
    irq[0] = 1'b1;
    wait_cmd(1, 20, "mid cmd");
    tick(1);
    rst_n = 1'b0;
    irq = '0;
    #1;
    check("mid rst ack", 68'(ack), 68'h0);
    check("mid rst cmd_obj", tif.tlx_cmd_obj, 68'h0);
    check("mid rst cmd_tag", 68'(tif.tlx_cmd_afutag), 68'h0);
    check("mid rst cmd_op", 68'(tif.tlx_cmd_opcode), 68'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    e0 = err_cnt;
    send_rsp(0, 16'hC000, 8'h0C, RSP_DONE);
    tick(3);
    check("late rsp err", 68'(err_cnt - e0), 68'd1);
    check("late rsp ack", 68'(ack), 68'h0);

    // Retry budget of 2 on the second instance: three commands, then failed ack.
    do_reset();
    src2[0 +: SW] = 64'h22;
    irq2[0] = 1'b1;
    for (int a = 0; a < 3; a++) begin
      k = 0;
      while (cmd2_n < a + 1 && k < 100) begin
        tick(1);
        k++;
      end
      if (cmd2_n < a + 1) timeout("rb cmd");
      send_rsp(1, 16'hC000, 8'h0C, RSP_RTY_REQ);
    end
    k = 0;
    while (!ack2[0] && k < 200) begin
      tick(1);
      k++;
    end
    check("rb ack", 68'(ack2[0]), 68'h1);
    check("rb fail", 68'(fail2[0]), 68'h1);
    tick(5);
    check("rb cmd count", 68'(cmd2_n), 68'd3);
    irq2[0] = 1'b0;
    tick(1);
    check("rb ack drop", 68'(ack2), 68'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
